// File: rtl/imem_loader.sv
// imem_loader: boot loader that turns a UART byte frame into instruction memory writes
// Frame: MAGIC, LEN_LO, LEN_HI, 4*LEN payload bytes (little-endian words), CSUM (XOR of payload)
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   rx_data_in, rx_valid_in  incoming byte stream; rx_ready_out low only while in error
//   err_clr_in               pulse that leaves the error state
//   imem_addr_out/data/we    instruction memory write port (byte address, word, one-cycle strobe)
//   cpu_rst_n_out, done_out  core released and frame verified
//   err_out, err_code_out    sticky error and cause: 1 bad length, 2 checksum, 3 timeout
module imem_loader #(
   parameter int IMEM_DEPTH_WORDS = 1024,
   parameter int IMEM_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0] MAGIC = 8'hA5
) (
   input  logic clk,
   input  logic rst,
   input  logic [7:0] rx_data_in,
   input  logic rx_valid_in,
   output logic rx_ready_out,
   input  logic err_clr_in,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_out,
   output logic [31:0] imem_data_out,
   output logic imem_we_out,
   output logic cpu_rst_n_out,
   output logic done_out,
   output logic err_out,
   output logic [1:0] err_code_out
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
   state_t state, state_n;
   logic [1:0] code_n;
   logic [15:0] len, len_full;
   logic [IMEM_ADDR_WIDTH-3:0] widx;
   logic [1:0] lane;
   logic [7:0] csum;
   logic [23:0] asm_word;
   logic [TW-1:0] tcnt;
   logic acc, timed, expire, last;
   assign rx_ready_out = state != ERR;
   assign err_out = state == ERR;
   assign acc = rx_valid_in && rx_ready_out;
   assign timed = state inside {LEN_LO, LEN_HI, DATA, CSUM};
   // an accepted byte always beats an expiring timeout
   assign expire = timed && !acc && tcnt == TW'(TIMEOUT_CYCLES - 1);
   assign len_full = {rx_data_in, len[7:0]};
   assign last = lane == 2'd3 && 16'(widx) == len - 16'd1;
   always_comb begin
      state_n = state;
      code_n = err_code_out;
      if (expire) begin
         state_n = ERR;
         code_n = 2'd3;
      end else begin
         case (state)
            IDLE, DONE: if (acc && rx_data_in == MAGIC) state_n = LEN_LO;
            LEN_LO: if (acc) state_n = LEN_HI;
            LEN_HI: if (acc) begin
               state_n = (len_full == '0 || len_full > 16'(IMEM_DEPTH_WORDS)) ? ERR : DATA;
               code_n = (state_n == ERR) ? 2'd1 : code_n;
            end
            DATA: if (acc && last) state_n = CSUM;
            CSUM: if (acc) begin
               state_n = (rx_data_in == csum) ? DONE : ERR;
               code_n = (state_n == ERR) ? 2'd2 : code_n;
            end
            ERR: if (err_clr_in) begin
               state_n = IDLE;
               code_n = 2'd0;
            end
            default: state_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         err_code_out <= '0;
         cpu_rst_n_out <= 1'b0;
         done_out <= 1'b0;
         imem_we_out <= 1'b0;
         imem_addr_out <= '0;
         imem_data_out <= '0;
         len <= '0;
         widx <= '0;
         lane <= '0;
         csum <= '0;
         asm_word <= '0;
         tcnt <= '0;
      end else begin
         state <= state_n;
         err_code_out <= code_n;
         cpu_rst_n_out <= state_n == DONE;
         done_out <= state_n == DONE;
         imem_we_out <= 1'b0;
         tcnt <= (timed && !acc && !expire) ? tcnt + 1'b1 : '0;
         if (acc) begin
            case (state)
               LEN_LO: len[7:0] <= rx_data_in;
               LEN_HI: begin
                  len[15:8] <= rx_data_in;
                  widx <= '0;
                  lane <= '0;
                  csum <= '0;
               end
               DATA: begin
                  csum <= csum ^ rx_data_in;
                  lane <= lane + 2'd1;
                  // lanes 0-2 collect in asm_word; lane 3 goes straight to the output register
                  if (lane == 2'd3) begin
                     imem_we_out <= 1'b1;
                     imem_data_out <= {rx_data_in, asm_word};
                     imem_addr_out <= {widx, 2'b00};
                     widx <= widx + 1'b1;
                  end else begin
                     asm_word <= lane == 2'd0 ? {asm_word[23:8], rx_data_in} :
                                 lane == 2'd1 ? {asm_word[23:16], rx_data_in, asm_word[7:0]} :
                                                {rx_data_in, asm_word[15:0]};
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
   localparam int AW = 12;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] rx_data_in = '0;
   logic rx_valid_in = 1'b0;
   logic err_clr_in = 1'b0;
   logic rx_ready_out, imem_we_out, cpu_rst_n_out, done_out, err_out;
   logic [AW-1:0] imem_addr_out;
   logic [31:0] imem_data_out;
   logic [1:0] err_code_out;
   int n_cmp = 0;
   int n_bad = 0;
   logic [AW-1:0] wa[$];
   logic [31:0] wd[$];
   logic [7:0] q[$];
   logic [7:0] burst_b[20] = '{8'hA5, 8'h04, 8'h00,
      8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
      8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12, 8'hBA};
   logic [31:0] burst_w[4] = '{32'h00000013, 32'h00100093, 32'hDEADBEEF, 32'h12345678};
   imem_loader #(.IMEM_DEPTH_WORDS(1024), .IMEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16), .MAGIC(8'hA5)) dut (
      .clk(clk), .rst(rst), .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
      .rx_ready_out(rx_ready_out), .err_clr_in(err_clr_in), .imem_addr_out(imem_addr_out),
      .imem_data_out(imem_data_out), .imem_we_out(imem_we_out), .cpu_rst_n_out(cpu_rst_n_out),
      .done_out(done_out), .err_out(err_out), .err_code_out(err_code_out));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (imem_we_out) begin
         wa.push_back(imem_addr_out);
         wd.push_back(imem_data_out);
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data_in = b;
      rx_valid_in = 1'b1;
      @(negedge clk);
      rx_valid_in = 1'b0;
   endtask
   task automatic send_q();
      while (q.size() > 0) send(q.pop_front());
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic clr_err();
      @(negedge clk);
      err_clr_in = 1'b1;
      @(negedge clk);
      err_clr_in = 1'b0;
   endtask
   task automatic check_reset(input string t);
      chk({t, ".ready"}, 32'(rx_ready_out), 1);
      chk({t, ".we"}, 32'(imem_we_out), 0);
      chk({t, ".addr"}, 32'(imem_addr_out), 0);
      chk({t, ".data"}, imem_data_out, 0);
      chk({t, ".cpu_rst_n"}, 32'(cpu_rst_n_out), 0);
      chk({t, ".done"}, 32'(done_out), 0);
      chk({t, ".err"}, 32'(err_out), 0);
      chk({t, ".code"}, 32'(err_code_out), 0);
   endtask
   initial begin
      @(negedge clk);
      check_reset("por");
      rst = 1'b0;
      q = '{8'h00, 8'hFF};
      send_q();
      chk("garbage.err", 32'(err_out), 0);
      chk("garbage.cpu_rst_n", 32'(cpu_rst_n_out), 0);
      q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      send_q();
      chk("good.done", 32'(done_out), 1);
      chk("good.cpu_rst_n", 32'(cpu_rst_n_out), 1);
      chk("good.err", 32'(err_out), 0);
      chk("good.nwr", 32'(wa.size()), 2);
      if (wa.size() == 2) begin
         chk("good.a0", 32'(wa[0]), 32'h000);
         chk("good.d0", wd[0], 32'h00000013);
         chk("good.a1", 32'(wa[1]), 32'h004);
         chk("good.d1", wd[1], 32'h00100093);
      end
      clr_err();
      chk("clr_idle.done", 32'(done_out), 1);
      chk("clr_idle.code", 32'(err_code_out), 0);
      send(8'hA5);
      chk("restart.cpu_rst_n", 32'(cpu_rst_n_out), 0);
      chk("restart.done", 32'(done_out), 0);
      wa.delete();
      wd.delete();
      q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
      send_q();
      chk("badcs.nwr", 32'(wa.size()), 2);
      if (wd.size() == 2) chk("badcs.d1", wd[1], 32'h00100093);
      chk("badcs.err", 32'(err_out), 1);
      chk("badcs.code", 32'(err_code_out), 2);
      chk("badcs.cpu_rst_n", 32'(cpu_rst_n_out), 0);
      chk("badcs.ready", 32'(rx_ready_out), 0);
      clr_err();
      chk("badcs_clr.err", 32'(err_out), 0);
      chk("badcs_clr.code", 32'(err_code_out), 0);
      chk("badcs_clr.ready", 32'(rx_ready_out), 1);
      wa.delete();
      wd.delete();
      q = '{8'hA5, 8'h00, 8'h00};
      send_q();
      chk("len0.err", 32'(err_out), 1);
      chk("len0.code", 32'(err_code_out), 1);
      clr_err();
      q = '{8'hA5, 8'h01, 8'h04};
      send_q();
      chk("len401.err", 32'(err_out), 1);
      chk("len401.code", 32'(err_code_out), 1);
      chk("len.nwr", 32'(wa.size()), 0);
      clr_err();
      q = '{8'hA5, 8'h02};
      send_q();
      idle(15);
      chk("to15.err", 32'(err_out), 0);
      idle(1);
      chk("to16.err", 32'(err_out), 1);
      chk("to16.code", 32'(err_code_out), 3);
      clr_err();
      q = '{8'hA5, 8'h02};
      send_q();
      idle(15);
      rx_data_in = 8'h00;
      rx_valid_in = 1'b1;
      @(negedge clk);
      rx_valid_in = 1'b0;
      chk("towin.err", 32'(err_out), 0);
      idle(15);
      chk("towin15.err", 32'(err_out), 0);
      idle(1);
      chk("towin16.err", 32'(err_out), 1);
      chk("towin16.code", 32'(err_code_out), 3);
      clr_err();
      for (int i = 0; i < 21; i++) begin
         int j;
         @(negedge clk);
         j = i - 4;
         chk($sformatf("burst.ready%0d", i), 32'(rx_ready_out), 1);
         chk($sformatf("burst.we%0d", i), 32'(imem_we_out), 32'(j >= 0 && j <= 15 && j % 4 == 3));
         if (j >= 0 && j <= 15 && j % 4 == 3) begin
            chk($sformatf("burst.addr%0d", i), 32'(imem_addr_out), 32'(j - 3));
            chk($sformatf("burst.data%0d", i), imem_data_out, burst_w[j / 4]);
         end
         if (i < 20) begin
            rx_data_in = burst_b[i];
            rx_valid_in = 1'b1;
         end else begin
            rx_valid_in = 1'b0;
         end
      end
      chk("burst.done", 32'(done_out), 1);
      chk("burst.cpu_rst_n", 32'(cpu_rst_n_out), 1);
      q = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11};
      send_q();
      chk("mid.data", imem_data_out, 32'hDEADBEEF);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset("mid");
      @(negedge clk);
      rst = 1'b0;
      q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      send_q();
      chk("after.done", 32'(done_out), 1);
      chk("after.data", imem_data_out, 32'h12345678);
      chk("after.addr", 32'(imem_addr_out), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
